// File: rtl/regfile_param.sv
// Parametrised register file: one byte-masked write port, two combinational
// read ports with optional write-through bypass, optional hardwired-zero
// register 0, and a self-timed sweep that clears one register per cycle.
module regfile_param #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                writeenable,
   input  logic [ADDR_W-1:0]   writeAddr,
   input  logic [WIDTH-1:0]    writeIn,
   input  logic [WIDTH/8-1:0]  byteEnable,
   input  logic [ADDR_W-1:0]   readAddrA,
   input  logic [ADDR_W-1:0]   readAddrB,
   output logic [WIDTH-1:0]    readA,
   output logic [WIDTH-1:0]    readB,
   input  logic                clearStart,
   output logic                clearBusy,
   output logic                clearDone
);

   localparam int unsigned NBYTES = WIDTH / 8;
   // Pointer is one bit wider than the address so DEPTH == 2**ADDR_W cannot wrap.
   localparam logic [ADDR_W:0] DepthW  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] LastPtr = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

   state_e             state_q, state_d;
   logic [ADDR_W:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0]   regs_q [DEPTH];
   logic [WIDTH-1:0]   regs_d [DEPTH];

   logic [WIDTH-1:0]   wr_mask;
   logic [WIDTH-1:0]   wr_old;
   logic [WIDTH-1:0]   wr_merged;
   logic               wr_commit;

   // Decide whether this cycle's write lands, and build the merged word.
   always_comb begin
      wr_mask = '0;
      for (int unsigned b = 0; b < NBYTES; b++) begin
         wr_mask[8*b +: 8] = {8{byteEnable[b]}};
      end
      wr_old = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (writeAddr == ADDR_W'(i)) wr_old = regs_q[i];
      end
      wr_merged = (wr_old & ~wr_mask) | (writeIn & wr_mask);
      wr_commit = reset && writeenable && ({1'b0, writeAddr} < DepthW);
      if (ZERO_REG && (writeAddr == '0)) wr_commit = 1'b0;
      // Addresses at or above the sweep pointer would be erased anyway; the
      // clear also wins over a write to the very register it zeroes.
      if ((state_q == StSweep) && ({1'b0, writeAddr} >= ptr_q)) wr_commit = 1'b0;
   end

   // Combinational read ports with optional write-through bypass.
   always_comb begin
      readA = '0;
      readB = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (readAddrA == ADDR_W'(i)) readA = regs_q[i];
         if (readAddrB == ADDR_W'(i)) readB = regs_q[i];
      end
      if (BYPASS && wr_commit && (readAddrA == writeAddr)) readA = wr_merged;
      if (BYPASS && wr_commit && (readAddrB == writeAddr)) readB = wr_merged;
      if (ZERO_REG && (readAddrA == '0)) readA = '0;
      if (ZERO_REG && (readAddrB == '0)) readB = '0;
      if (!reset) begin
         readA = '0;
         readB = '0;
      end
   end

   // Next register contents: committed write, then the sweep clear.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_commit && (writeAddr == ADDR_W'(i))) regs_d[i] = wr_merged;
         if ((state_q == StSweep) && (ptr_q == (ADDR_W + 1)'(i))) regs_d[i] = '0;
      end
   end

   // Storage array, cleared asynchronously.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      end
   end

   // Sweep FSM state and pointer register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Sweep FSM next state; start requests outside IDLE are dropped.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            ptr_d = '0;
            if (clearStart) state_d = StSweep;
         end
         StSweep: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LastPtr) begin
               state_d = StDone;
               ptr_d   = '0;
            end
         end
         StDone: begin
            state_d = StIdle;
            ptr_d   = '0;
         end
         default: begin
            state_d = StIdle;
            ptr_d   = '0;
         end
      endcase
   end

   // Sweep FSM outputs.
   always_comb begin
      clearBusy = (state_q == StSweep);
      clearDone = (state_q == StDone);
   end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised multi-register storage block; generalises the single 32-bit enabled register to DEPTH words of WIDTH bits.
- Provides one write port with byte enables, two asynchronous read ports with write-through bypass, and an optional hardwired-zero register 0.
- Includes a self-timed clear-all sweep FSM that zeroes one register per cycle without a global reset.
- Sits in the processor datapath as the architectural register file; also reused for game-state scratch storage.

Parameters:
- WIDTH, 32: data width in bits. Must be a multiple of 8.
- DEPTH, 32: number of registers. Range 2..2^ADDR_W.
- ADDR_W, 5: address width.
- ZERO_REG, 1: when 1, register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1: when 1, a read of the address being written returns the merged write data in the same cycle.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset. Asserted when 0.
- writeenable, input, 1: write request this cycle.
- writeAddr, input, ADDR_W: write address.
- writeIn, input, WIDTH: write data.
- byteEnable, input, WIDTH/8: per-byte write mask. Bit i covers bits [8i+7:8i].
- readAddrA, input, ADDR_W: read port A address.
- readAddrB, input, ADDR_W: read port B address.
- readA, output, WIDTH: read port A data (combinational).
- readB, output, WIDTH: read port B data (combinational).
- clearStart, input, 1: request a clear-all sweep.
- clearBusy, output, 1: high while the sweep is in progress.
- clearDone, output, 1: one-cycle pulse when the sweep completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers cleared to 0.
  - FSM goes to IDLE; sweep pointer cleared to 0.
  - clearBusy=0, clearDone=0.
  - readA and readB show 0 while reset is held.
  - Release of reset takes effect at the next rising edge.
- Write commit:
  - A write commits at the rising edge when writeenable=1, writeAddr<DEPTH, and the write is not blocked by ZERO_REG or the sweep rules below.
  - Committed value is (old & ~mask) | (writeIn & mask), where mask is byteEnable expanded to WIDTH bits.
  - byteEnable=0 leaves the register unchanged.
- Reads:
  - readX = reg[readAddrX], combinational.
  - readAddrX>=DEPTH returns 0.
  - When ZERO_REG=1, address 0 returns 0.
  - Both ports may read the same address in the same cycle.
- Bypass (BYPASS=1):
  - If a write will commit this edge and readAddrX==writeAddr, readX shows the merged value in the same cycle.
  - Blocked writes are never bypassed.
  - When BYPASS=0, readX shows the old value until after the edge.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE: clearStart=1 at an edge moves to SWEEP with ptr=0.
  - SWEEP: each edge sets reg[ptr]=0 and increments ptr. The edge that clears DEPTH-1 moves to DONE.
  - SWEEP therefore lasts exactly DEPTH cycles.
  - DONE: lasts one cycle with clearDone=1, then returns to IDLE. ptr returns to 0.
  - clearBusy=1 only in SWEEP.
  - clearStart in SWEEP or DONE is ignored; requests are not queued.
- Writes during SWEEP:
  - writeAddr<ptr (already cleared): commits normally.
  - writeAddr>=ptr: dropped, because it would be erased.
  - writeAddr==ptr on the same edge: the clear wins and the write is dropped.
  - Writes in DONE and IDLE commit normally.
- Reset asserted mid-sweep: the sweep aborts immediately, all registers become 0, the FSM returns to IDLE, and no clearDone pulse is generated.
- Widths: all arithmetic is unsigned. ptr is ADDR_W+1 bits so it cannot wrap when DEPTH=2^ADDR_W.

Test Plan:
1. Reset then write: hold reset=0 for 2 cycles, release, write reg 5=0xDEADBEEF with byteEnable=4'hF -> readA(addr 5)=0xDEADBEEF next cycle; all other addresses read 0.
2. Byte-masked write: reg 5=0xDEADBEEF, then write 0x11223344 with byteEnable=4'b0101 -> reg 5=0xDE22BE44. Same test with byteEnable=0 -> unchanged.
3. Zero register and bypass: write 0xFFFFFFFF to reg 0 -> reads 0. Write reg 7=0x00000123 with readAddrA=readAddrB=7 in the same cycle -> both ports show 0x123 before the edge (BYPASS=1); with BYPASS=0, old value before the edge and 0x123 after.
4. Sweep timing: fill regs 1..31 with nonzero values, pulse clearStart -> clearBusy high for exactly 32 cycles, clearDone high for 1 cycle after that, all regs 0. clearStart re-pulsed mid-sweep -> ignored.
5. Writes during sweep: at ptr=10, write reg 3=0xA5 -> commits (reads 0xA5 after sweep). Write reg 20 -> dropped (reads 0). Write reg 10 on the edge that clears it -> reads 0.
6. Reset mid-sweep: assert reset at ptr=15 -> clearBusy=0 immediately, all regs 0, no clearDone pulse. A new clearStart after reset release runs the full 32-cycle sweep.
